// File: rtl/image_line_streamer_if.sv
// image_line_streamer_if: pixel stream handshake between the line streamer and the image processor
interface image_line_streamer_if #(parameter int DATA_WIDTH = 12);
  logic                  o_data_valid;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_line_last;
  logic                  i_data_ready;
  modport master (output o_data_valid, o_data, o_line_last, input i_data_ready);
  modport slave (input o_data_valid, o_data, o_line_last, output i_data_ready);
endinterface

// File: rtl/image_line_streamer.sv
// image_line_streamer: streams a frame buffer line by line, paced by line-done interrupt credits
module image_line_streamer #(
  parameter int DATA_WIDTH  = 12,
  parameter int LINE_LEN    = 512,
  parameter int NUM_LINES   = 512,
  parameter int PRIME_LINES = 4,
  parameter int PAD_LINES   = 2,
  parameter int ADDR_WIDTH  = 18
) (
  input  logic                  axi_clk,
  input  logic                  axi_reset,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  input  logic                  i_intr,
  output logic                  o_credit_ovf,
  image_line_streamer_if.master s_axis
);
  localparam int PL = NUM_LINES < PRIME_LINES ? NUM_LINES : PRIME_LINES;
  localparam int PW = $clog2(LINE_LEN + 1);
  localparam int LW = $clog2(NUM_LINES + 1);
  localparam int DW = $clog2(PAD_LINES + 2);
  typedef enum logic [2:0] {IDLE, PRIME, WAIT_INTR, LINE, PAD_WAIT, PAD_LINE, DRAIN} state_t;
  localparam state_t AFTER_IMAGE = PAD_LINES > 0 ? PAD_WAIT : DRAIN;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [PW-1:0]         pix_q, pix_d, out_q, out_d;
  logic [LW-1:0]         line_q, line_d;
  logic [DW-1:0]         pad_q, pad_d;
  logic [1:0]            cred_q, cred_d, cnt_q, cnt_d;
  logic                  ovf_q, ovf_d, rd_ptr_q, rd_ptr_d, intr_q, inflight_q;
  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic [DATA_WIDTH-1:0] fifo_d [2];
  logic                  pop, push, room, issue, last_pix, intr_rise, consume;
  assign s_axis.o_data_valid = cnt_q != 2'd0;
  assign s_axis.o_data       = fifo_q[rd_ptr_q];
  assign s_axis.o_line_last  = s_axis.o_data_valid && out_q == PW'(LINE_LEN - 1);
  assign o_mem_addr          = addr_q;
  assign o_credit_ovf        = ovf_q;
  // Next state: FIFO occupancy throttles reads/pad pushes, interrupt edges bank credits, FSM walks the frame
  always_comb begin
    pop         = s_axis.o_data_valid && s_axis.i_data_ready;
    room        = ({1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, pop}) < 3'd2;
    issue       = room && (state_q == PRIME || state_q == LINE || state_q == PAD_LINE);
    last_pix    = pix_q == PW'(LINE_LEN - 1);
    intr_rise   = i_intr && !intr_q && state_q != IDLE;
    consume     = (state_q == WAIT_INTR || state_q == PAD_WAIT) && cred_q != 2'd0;
    push        = inflight_q || (issue && state_q == PAD_LINE);
    o_mem_rd_en = issue && state_q != PAD_LINE;
    o_done      = state_q == DRAIN && cnt_q == 2'd0 && !inflight_q;
    o_busy      = state_q != IDLE && !o_done;
    state_d     = state_q;
    addr_d      = o_mem_rd_en ? addr_q + 1'b1 : addr_q;
    pix_d       = issue ? (last_pix ? '0 : pix_q + 1'b1) : pix_q;
    line_d      = line_q;
    pad_d       = pad_q;
    cred_d      = state_q == IDLE ? 2'd0 :
                  intr_rise && !consume ? (cred_q == 2'd3 ? cred_q : cred_q + 2'd1) :
                  consume && !intr_rise ? cred_q - 2'd1 : cred_q;
    ovf_d       = ovf_q || (intr_rise && !consume && cred_q == 2'd3);
    fifo_d      = fifo_q;
    if (push) fifo_d[rd_ptr_q ^ cnt_q[0]] = inflight_q ? i_mem_data : '0;
    rd_ptr_d    = rd_ptr_q ^ pop;
    cnt_d       = cnt_q + {1'b0, push} - {1'b0, pop};
    out_d       = pop ? (out_q == PW'(LINE_LEN - 1) ? '0 : out_q + 1'b1) : out_q;
    case (state_q)
      IDLE: begin
        addr_d = '0;
        pix_d  = '0;
        line_d = '0;
        pad_d  = '0;
        if (i_start) state_d = PRIME;
      end
      PRIME: if (issue && last_pix) begin
        line_d = line_q + 1'b1;
        if (line_q == LW'(PL - 1)) state_d = NUM_LINES <= PRIME_LINES ? AFTER_IMAGE : WAIT_INTR;
      end
      WAIT_INTR: if (consume) state_d = LINE;
      LINE: if (issue && last_pix) begin
        line_d  = line_q + 1'b1;
        state_d = line_q == LW'(NUM_LINES - 1) ? AFTER_IMAGE : WAIT_INTR;
      end
      PAD_WAIT: if (consume) state_d = PAD_LINE;
      PAD_LINE: if (issue && last_pix) begin
        pad_d   = pad_q + 1'b1;
        state_d = pad_q == DW'(PAD_LINES - 1) ? DRAIN : PAD_WAIT;
      end
      DRAIN: if (o_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // State register; reset drops any read still in flight so its data is never pushed
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      pix_q      <= '0;
      out_q      <= '0;
      line_q     <= '0;
      pad_q      <= '0;
      cred_q     <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      rd_ptr_q   <= 1'b0;
      intr_q     <= 1'b0;
      inflight_q <= 1'b0;
      fifo_q     <= '{default: '0};
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      pix_q      <= pix_d;
      out_q      <= out_d;
      line_q     <= line_d;
      pad_q      <= pad_d;
      cred_q     <= cred_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      rd_ptr_q   <= rd_ptr_d;
      intr_q     <= i_intr;
      inflight_q <= o_mem_rd_en;
      fifo_q     <= fifo_d;
    end
  end
endmodule

// File: doc/image_line_streamer.md
Name: image_line_streamer

Overview:
- Master-side pixel source for the image processing top. It streams a stored image into the processor's slave stream interface one line at a time.
- Startup: sends PRIME_LINES lines back-to-back. After that, each further line requires one line-done interrupt from the processor.
- End of image: appends PAD_LINES all-zero lines so the processor can flush its bottom rows.
- Pixel source: a synchronous image RAM (frame buffer) with one-cycle read latency.

Parameters:
- DATA_WIDTH, 12, pixel width (8 integer + 4 fractional bits).
- LINE_LEN, 512, pixels per line.
- NUM_LINES, 512, image lines held in RAM.
- PRIME_LINES, 4, lines sent before the first interrupt is required.
- PAD_LINES, 2, trailing zero lines.
- ADDR_WIDTH, 18, RAM address width; must satisfy 2^ADDR_WIDTH >= LINE_LEN*NUM_LINES.

Ports:
- axi_clk, in, 1, sole clock.
- axi_reset, in, 1, synchronous active-high reset.
- i_start, in, 1, one-cycle start pulse; sampled only in IDLE.
- o_busy, out, 1, high from the cycle after an accepted start until o_done.
- o_done, out, 1, one-cycle pulse after the last pad pixel is accepted.
- o_mem_rd_en, out, 1, RAM read enable.
- o_mem_addr, out, ADDR_WIDTH, RAM read address, row-major, starts at 0.
- i_mem_data, in, DATA_WIDTH, RAM data, valid the cycle after o_mem_rd_en.
- o_data_valid, out, 1, stream valid.
- o_data, out, DATA_WIDTH, pixel.
- o_line_last, out, 1, qualifies the last pixel of each line (image or pad).
- i_data_ready, in, 1, stream ready.
- i_intr, in, 1, line-done interrupt from the processor; level input, rising edge counted.
- o_credit_ovf, out, 1, sticky error flag: credit counter overflowed.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; address, pixel and line counters 0; credits 0; output buffer empty.
- Reset mid-operation aborts the frame. Any RAM data returning in the cycle after reset is discarded.
- Stream handshake: a transfer occurs when o_data_valid && i_data_ready.
  - Once asserted, o_data_valid, o_data and o_line_last hold stable until the transfer.
  - Sustained throughput is one pixel per cycle while i_data_ready=1.
- Output buffering: 2-entry FIFO.
  - Issue a RAM read only if (fifo_count + reads_in_flight − pop_this_cycle) < 2.
  - Read data is pushed into the FIFO the cycle after o_mem_rd_en.
  - First o_data_valid occurs 2 cycles after the line's first read.
- Interrupt credits:
  - i_intr is registered; a rising edge (i_intr & ~i_intr_q) adds 1 credit.
  - Credit counter is 2 bits, saturating at 3. An edge arriving while credits=3 sets o_credit_ovf; it stays set until reset.
  - Edge and consumption in the same cycle: net change 0.
  - Credits count from the cycle after start. Edges seen during PRIME are banked.
- FSM states:
  - IDLE: on i_start go to PRIME; o_busy=1 from the next cycle.
  - PRIME: issue reads for PRIME_LINES*LINE_LEN consecutive addresses, throttled by the FIFO rule. When the last read is issued, go to WAIT_INTR.
    - If NUM_LINES <= PRIME_LINES, PRIME covers only NUM_LINES lines, then go to PAD_WAIT.
  - WAIT_INTR: if credits>0, consume 1 credit and go to LINE. LINE starts in the next cycle; the consuming cycle issues no read.
  - LINE: issue reads for LINE_LEN addresses. After the last read: WAIT_INTR if image lines remain, else PAD_WAIT.
  - PAD_WAIT: same as WAIT_INTR, but the destination is PAD_LINE.
  - PAD_LINE: push LINE_LEN zero pixels into the FIFO, with no RAM reads and the same occupancy rule. After the last push: PAD_WAIT if pad lines remain, else DRAIN.
  - DRAIN: wait until the FIFO is empty and no read is in flight, then pulse o_done; o_busy falls in the same cycle; return to IDLE.
- PAD_LINES=0: go from the last image line directly to DRAIN.
- Line framing: o_line_last=1 on every LINE_LEN-th transferred pixel, counted per pixel transferred, independent of state.
- Ignored inputs:
  - i_start outside IDLE.
  - i_data_ready when o_data_valid=0.
- Address rules: o_mem_addr increments only on issued reads and never wraps within a frame. Final read address = LINE_LEN*NUM_LINES−1.
- Totals: transferred pixels = (NUM_LINES+PAD_LINES)*LINE_LEN; interrupts consumed = NUM_LINES−PRIME_LINES+PAD_LINES.

Test Plan (LINE_LEN=8, NUM_LINES=6, PRIME_LINES=4, PAD_LINES=2, RAM[a]=a+1):
- Priming, ready=1, no intr:
  - Exactly 32 pixels with values 1..32, back-to-back after the 2-cycle fill.
  - o_line_last on pixels 8/16/24/32.
  - Then valid stays 0 indefinitely.
- Full frame, one i_intr pulse per line after each line completes:
  - 64 pixels total: 1..48 followed by 16 zeros.
  - 4 interrupts consumed.
  - o_done pulses once, 1 cycle after the 64th transfer.
  - o_busy=0 afterwards; o_credit_ovf=0.
- Random backpressure (i_data_ready toggled pseudo-randomly):
  - Identical 64-value sequence, no drops or duplicates.
  - o_data stable while valid && !ready.
- Three i_intr pulses during priming:
  - Lines 5, 6 and pad line 1 stream without waiting.
  - The 4th intr releases pad line 2.
  - A 4th banked pulse during priming instead sets o_credit_ovf=1.
- axi_reset for 1 cycle in the middle of line 5, then restart:
  - All outputs 0 the cycle after reset.
  - The new frame starts again from address 0, pixel value 1.
- i_start pulsed while busy: ignored, and the frame output is unchanged.
- Intr rising edge in the same cycle WAIT_INTR consumes the last credit: credits end at 1, and the next line proceeds without a further intr.
